// File: rtl/pid_sched_pkg.sv
// Shared types and default parameters for the PID scheduler: state encoding,
// timing defaults and a counter-width helper.
package pid_sched_pkg;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_SOFTSTART = 2'd1,
        ST_BALANCE   = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    localparam int RIDER_DEB_DEF  = 1024;
    localparam int WDOG_DEF       = 4096;
    localparam int OVR_LIMIT_DEF  = 3;
    localparam int FAULT_HOLD_DEF = 65536;

    localparam logic [7:0] SS_DONE = 8'hFF;

    // Bits needed to hold every value from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pid_sched_deb.sv
// Level debouncer: q follows d only after d has held the opposite level for
// DEPTH consecutive clocks; any return to the current level restarts the count.
module deb_filt
    import pid_sched_pkg::*;
#(
    parameter int DEPTH = RIDER_DEB_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int             CW   = cnt_width(DEPTH - 1);
    localparam logic [CW-1:0]  LAST = CW'(DEPTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_q, q_d;

    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (d == q_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            q_d   = d;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The filtered level powers up high so a missing rider is assumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            q_q   <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pid_sched.sv
// Power/balance scheduler for the PID loop: sequences OFF, SOFTSTART, BALANCE
// and FAULT, gates PID update strobes and guards against overcurrent and stalls.
module pid_sched
    import pid_sched_pkg::*;
#(
    parameter int RIDER_DEB  = RIDER_DEB_DEF,
    parameter int WDOG       = WDOG_DEF,
    parameter int OVR_LIMIT  = OVR_LIMIT_DEF,
    parameter int FAULT_HOLD = FAULT_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       stop,
    input  logic       sample_rdy,
    input  logic       ovr_i,
    input  logic       rider_off,
    input  logic [7:0] ss_tmr,
    output logic       vld,
    output logic       pwr_up,
    output logic       rider_off_q,
    output logic       en_steer,
    output logic       fault,
    output logic [1:0] state
);

    localparam int OVR_W  = cnt_width(OVR_LIMIT);
    localparam int WDOG_W = cnt_width(WDOG);
    localparam int HOLD_W = cnt_width(FAULT_HOLD - 1);

    localparam logic [OVR_W-1:0]  OVR_MAX   = OVR_W'(OVR_LIMIT);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FAULT_HOLD - 1);

    state_t            state_q, state_d;
    logic [OVR_W-1:0]  ovr_cnt_q, ovr_cnt_d;
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              vld_q, vld_d;
    logic              pwr_up_q, pwr_up_d;
    logic              en_steer_q, en_steer_d;
    logic              fault_q, fault_d;
    logic              rider_deb;
    logic              active, next_active, trip;

    deb_filt #(
        .DEPTH (RIDER_DEB)
    ) u_rider_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rider_off),
        .q     (rider_deb)
    );

    assign active      = (state_q == ST_SOFTSTART) || (state_q == ST_BALANCE);
    assign next_active = (state_d == ST_SOFTSTART) || (state_d == ST_BALANCE);
    assign trip        = (ovr_cnt_q >= OVR_MAX) || (wdog_cnt_q >= WDOG_MAX);

    // Next-state logic; stop wins over any pending fault while powered.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        case (state_q)
            ST_OFF: begin
                if (go && !stop) state_d = ST_SOFTSTART;
            end
            ST_SOFTSTART: begin
                if (stop)                   state_d = ST_OFF;
                else if (trip)              state_d = ST_FAULT;
                else if (ss_tmr == SS_DONE) state_d = ST_BALANCE;
            end
            ST_BALANCE: begin
                if (stop)      state_d = ST_OFF;
                else if (trip) state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (hold_cnt_q == HOLD_LAST) state_d = ST_OFF;
                else                         hold_cnt_d = hold_cnt_q + 1'b1;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Supervision counters only run while powered and restart on every entry.
    always_comb begin
        ovr_cnt_d  = ovr_cnt_q;
        wdog_cnt_d = wdog_cnt_q;
        if (!next_active || !active) begin
            ovr_cnt_d  = '0;
            wdog_cnt_d = '0;
        end else if (sample_rdy) begin
            wdog_cnt_d = '0;
            if (!ovr_i)                    ovr_cnt_d = '0;
            else if (ovr_cnt_q >= OVR_MAX) ovr_cnt_d = OVR_MAX;
            else                           ovr_cnt_d = ovr_cnt_q + 1'b1;
        end else if (wdog_cnt_q >= WDOG_MAX) begin
            wdog_cnt_d = WDOG_MAX;
        end else begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
    end

    // Outputs are computed from the state being entered so they register in step.
    always_comb begin
        vld_d      = sample_rdy && active && next_active;
        pwr_up_d   = next_active;
        en_steer_d = (state_d == ST_BALANCE) && !rider_deb;
        fault_d    = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            ovr_cnt_q  <= '0;
            wdog_cnt_q <= '0;
            hold_cnt_q <= '0;
            vld_q      <= 1'b0;
            pwr_up_q   <= 1'b0;
            en_steer_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ovr_cnt_q  <= ovr_cnt_d;
            wdog_cnt_q <= wdog_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            vld_q      <= vld_d;
            pwr_up_q   <= pwr_up_d;
            en_steer_q <= en_steer_d;
            fault_q    <= fault_d;
        end
    end

    assign vld         = vld_q;
    assign pwr_up      = pwr_up_q;
    assign en_steer    = en_steer_q;
    assign fault       = fault_q;
    assign state       = state_q;
    assign rider_off_q = rider_deb;

endmodule

// File: tb/tb_pid_sched.sv
// Directed self-checking bench for pid_sched with default timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pid_sched;

    logic       clk;
    logic       rst_n;
    logic       go;
    logic       stop;
    logic       sample_rdy;
    logic       ovr_i;
    logic       rider_off;
    logic [7:0] ss_tmr;
    logic       vld;
    logic       pwr_up;
    logic       rider_off_q;
    logic       en_steer;
    logic       fault;
    logic [1:0] state;

    int checkCount;
    int errorCount;

    pid_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .stop        (stop),
        .sample_rdy  (sample_rdy),
        .ovr_i       (ovr_i),
        .rider_off   (rider_off),
        .ss_tmr      (ss_tmr),
        .vld         (vld),
        .pwr_up      (pwr_up),
        .rider_off_q (rider_off_q),
        .en_steer    (en_steer),
        .fault       (fault),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive the control inputs, then let n falling edges pass.
    task automatic applyStimulus(input logic g, input logic s, input logic smp,
                                 input logic ov, input int n);
        go         = g;
        stop       = s;
        sample_rdy = smp;
        ovr_i      = ov;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseSample(input logic ov);
        applyStimulus(1'b0, 1'b0, 1'b1, ov, 1);
        sample_rdy = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, 32'(state), 0);
        checkOutput({tag, "_vld"}, 32'(vld), 0);
        checkOutput({tag, "_pwr_up"}, 32'(pwr_up), 0);
        checkOutput({tag, "_en_steer"}, 32'(en_steer), 0);
        checkOutput({tag, "_fault"}, 32'(fault), 0);
        checkOutput({tag, "_rider_off_q"}, 32'(rider_off_q), 1);
    endtask

    task automatic enterBalance();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("enter_ss", 32'(state), 1);
        ss_tmr = 8'hFF;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
        ss_tmr = 8'h00;
        checkOutput("enter_bal", 32'(state), 2);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n      = 1'b0;
        go         = 1'b0;
        stop       = 1'b0;
        sample_rdy = 1'b0;
        ovr_i      = 1'b0;
        rider_off  = 1'b1;
        ss_tmr     = 8'h00;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2);
        checkOutput("idle_state", 32'(state), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("go_stop_state", 32'(state), 0);
        checkOutput("go_stop_pwr", 32'(pwr_up), 0);

        // Soft start then balance after 50 clocks of timer.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("ss_state", 32'(state), 1);
        checkOutput("ss_pwr_up", 32'(pwr_up), 1);
        checkOutput("ss_en_steer", 32'(en_steer), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 49);
        checkOutput("ss_hold_state", 32'(state), 1);
        ss_tmr = 8'hFF;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
        ss_tmr = 8'h00;
        checkOutput("bal_state", 32'(state), 2);
        checkOutput("bal_pwr_up", 32'(pwr_up), 1);
        checkOutput("bal_en_steer_rider_off", 32'(en_steer), 0);

        // One vld per sample, one clock late.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 19);
            checkOutput("vld_before", 32'(vld), 0);
            pulseSample(1'b0);
            checkOutput("vld_pulse", 32'(vld), 1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
            checkOutput("vld_after", 32'(vld), 0);
        end

        // Two overcurrent samples then a clean one: no fault.
        pulseSample(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4);
        pulseSample(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4);
        pulseSample(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4);
        checkOutput("ovr2_state", 32'(state), 2);
        checkOutput("ovr2_fault", 32'(fault), 0);

        // Three overcurrent samples: fault one clock after the third.
        pulseSample(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4);
        pulseSample(1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4);
        pulseSample(1'b1);
        checkOutput("ovr3_pre_state", 32'(state), 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("ovr3_state", 32'(state), 3);
        checkOutput("ovr3_fault", 32'(fault), 1);
        checkOutput("ovr3_pwr_up", 32'(pwr_up), 0);
        checkOutput("ovr3_en_steer", 32'(en_steer), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1);
        checkOutput("fault_vld", 32'(vld), 0);
        checkOutput("fault_go_stop_state", 32'(state), 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 65534);
        checkOutput("fault_hold_last", 32'(state), 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("fault_exit_state", 32'(state), 0);
        checkOutput("fault_exit_fault", 32'(fault), 0);

        // No vld while OFF even with samples toggling.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, ((i % 2) == 0), 1'b0, 1);
            checkOutput("off_vld", 32'(vld), 0);
        end
        sample_rdy = 1'b0;

        // Watchdog: 4095 quiet clocks tolerated, 4096 trips.
        enterBalance();
        pulseSample(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4095);
        pulseSample(1'b0);
        checkOutput("wdog4095_state", 32'(state), 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4096);
        checkOutput("wdog4096_pre_state", 32'(state), 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("wdog_state", 32'(state), 3);
        checkOutput("wdog_fault", 32'(fault), 1);

        // Asynchronous reset while in FAULT.
        rst_n = 1'b0;
        #1;
        checkResetValues("rst_fault");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2);
        checkOutput("rst_fault_idle", 32'(state), 0);

        // Debounce with a glitch at count 500.
        enterBalance();
        rider_off = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 500);
        rider_off = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
        rider_off = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1023);
        checkOutput("deb_hold_q", 32'(rider_off_q), 1);
        checkOutput("deb_hold_steer", 32'(en_steer), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("deb_fall_q", 32'(rider_off_q), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("deb_steer", 32'(en_steer), 1);
        checkOutput("deb_state", 32'(state), 2);

        // Stop from BALANCE and from SOFTSTART.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("stop_bal_state", 32'(state), 0);
        checkOutput("stop_bal_pwr", 32'(pwr_up), 0);
        checkOutput("stop_bal_steer", 32'(en_steer), 0);
        checkOutput("stop_keeps_q", 32'(rider_off_q), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
        checkOutput("ss2_state", 32'(state), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("stop_ss_state", 32'(state), 0);

        // Reset in BALANCE with rider present.
        enterBalance();
        checkOutput("bal_rider_steer", 32'(en_steer), 1);
        rst_n = 1'b0;
        #1;
        checkResetValues("rst_bal");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("rst_bal_state", 32'(state), 0);
        checkOutput("rst_bal_pwr", 32'(pwr_up), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pid_sched.md
PID_SCHED -- requirements
Module: pid_sched

Interface
REQ-001 Parameter RIDER_DEB, default 1024; consecutive clocks rider_off must hold a new level before rider_off_q follows.
REQ-002 Parameter WDOG, default 4096; maximum clocks allowed between sample_rdy pulses in SOFTSTART or BALANCE.
REQ-003 Parameter OVR_LIMIT, default 3; consecutive sample periods with overcurrent that cause FAULT.
REQ-004 Parameter FAULT_HOLD, default 65536; clocks spent in FAULT before returning to OFF.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 go  input  1  power-on request, level, sampled each clock.
REQ-008 stop  input  1  power-off request, level, sampled each clock.
REQ-009 sample_rdy  input  1  one-clock pulse, new inertial sample available.
REQ-010 ovr_i  input  1  motor overcurrent flag, level.
REQ-011 rider_off  input  1  raw rider-absent indication.
REQ-012 ss_tmr  input  8  soft-start timer value returned from the PID block.
REQ-013 vld  output  1  one-clock PID update strobe.
REQ-014 pwr_up  output  1  enables PID soft-start timer and motor drive.
REQ-015 rider_off_q  output  1  debounced rider_off, drives PID rider_off.
REQ-016 en_steer  output  1  steering enable.
REQ-017 fault  output  1  high while in FAULT.
REQ-018 state  output  2  current state encoding: OFF=0, SOFTSTART=1, BALANCE=2, FAULT=3.

Function
REQ-019 OFF: pwr_up=0, vld=0, en_steer=0; go=1 and stop=0 -> SOFTSTART next clock.
REQ-020 SOFTSTART: pwr_up=1, en_steer=0; ss_tmr==8'hFF -> BALANCE next clock.
REQ-021 BALANCE: pwr_up=1; en_steer=~rider_off_q.
REQ-022 In SOFTSTART and BALANCE, vld shall be sample_rdy registered once: exactly one pulse per sample_rdy pulse, one-clock latency.
REQ-023 vld shall be 0 in OFF and FAULT regardless of sample_rdy.
REQ-024 Overcurrent counter: at each sample_rdy, increments (saturating at OVR_LIMIT) if ovr_i=1, clears if ovr_i=0; counter reaching OVR_LIMIT -> FAULT next clock.
REQ-025 Watchdog counter: clears on sample_rdy and on entry to SOFTSTART; reaching WDOG in SOFTSTART or BALANCE -> FAULT next clock.
REQ-026 FAULT: pwr_up=0, en_steer=0, fault=1; hold counter counts to FAULT_HOLD-1 then -> OFF; go ignored in FAULT.
REQ-027 stop=1 in SOFTSTART or BALANCE -> OFF next clock, taking priority over fault conditions; stop does not shorten FAULT.
REQ-028 Simultaneous go and stop in OFF: remain OFF.
REQ-029 Overcurrent and watchdog counters clear on every entry to OFF or FAULT.
REQ-030 rider_off_q changes only after rider_off has held the opposite level for RIDER_DEB consecutive clocks; any glitch restarts the count.
REQ-031 The debouncer runs in all states; rider_off_q is not reset by state changes.
REQ-032 All outputs registered; no combinational input-to-output path.

Reset
REQ-033 On rst_n low: state=OFF, vld=0, pwr_up=0, en_steer=0, fault=0, rider_off_q=1, all counters 0.
REQ-034 Reset asserted mid-operation (any state) takes effect immediately and asynchronously; after release the block is in OFF and requires a new go.

Structure
REQ-035 Package pid_sched_pkg shall hold the state enum (2-bit) and default values of RIDER_DEB, WDOG, OVR_LIMIT, FAULT_HOLD.
REQ-036 Debouncer shall be a separate sub-module deb_filt (parameter DEPTH, ports clk, rst_n, d, q; reset value 1).
REQ-037 Counter widths shall be derived from the parameters with $clog2.

Verification
REQ-038 go=1 one clock, ss_tmr driven to 8'hFF after 50 clocks -> state 0->1 then 2; pwr_up=1 from the clock after go.
REQ-039 BALANCE, sample_rdy every 20 clocks -> one vld per sample_rdy, one clock later; zero vld in OFF with sample_rdy toggling.
REQ-040 BALANCE, ovr_i=1 across 3 sample_rdy pulses -> fault=1, pwr_up=0; after 65536 clocks state=OFF; ovr_i=1 for only 2 then 0 -> no fault.
REQ-041 BALANCE, sample_rdy withheld 4096 clocks -> FAULT; withheld 4095 then pulsed -> stays BALANCE.
REQ-042 rider_off 1->0 with a 1-clock glitch at count 500 -> rider_off_q falls 1024 clocks after the glitch ends; en_steer follows in BALANCE.
REQ-043 rst_n pulsed low while in BALANCE -> all outputs at reset values immediately, state=OFF after release.
